mem_arbiter: RTL and testbench

Sequential arbiter sharing the single-ported RAM between the instruction-fetch and data-access paths of the single-cycle MIPS datapath. Sits between the datapath (fetch, and the dREN/dWEN/halt signals produced by instruction decode) and the RAM model. Grants one access at a time with data priority, latches the granted address and store data, returns one-cycle registered hit pulses with load data, and parks the memory system after halt.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one RAM port between instruction fetch and data access,
//            with data priority and a sticky halt park. Optional access
//            timeout enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DREQ  = 3'd1,
        S_IREQ  = 3'd2,
        S_DDONE = 3'd3,
        S_IDONE = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_wr;
    logic        r_halt_pend;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic [31:0] r_iload;
    logic [31:0] r_dload;
    logic        w_in_req;
    logic        w_data_req;
    logic        w_timeout;

    assign w_in_req   = (r_state == S_DREQ) || (r_state == S_IREQ);
    assign w_data_req = dREN || dWEN;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT_M1 = 8'(TIMEOUT - 1);

    logic [7:0] r_count;
    logic       r_err;

    // Count reaching TIMEOUT is detected one step early so the exit lands on it.
    assign w_timeout = w_in_req && !ram_ready && (r_count == c_TIMEOUT_M1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            if (!w_in_req)
                r_count <= 8'd0;
            else if (!ram_ready)
                r_count <= r_count + 8'd1;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT);
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (halt)
                    w_next = S_HALT;
                else if (w_data_req)
                    w_next = S_DREQ;
                else if (iREN)
                    w_next = S_IREQ;
            end
            S_DREQ: begin
                if (w_timeout)
                    w_next = S_HALT;
                else if (ram_ready)
                    w_next = S_DDONE;
            end
            S_IREQ: begin
                if (w_timeout)
                    w_next = S_HALT;
                else if (ram_ready)
                    w_next = S_IDONE;
            end
            S_DDONE, S_IDONE: begin
                if (halt || r_halt_pend)
                    w_next = S_HALT;
                else
                    w_next = S_IDLE;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr        <= 1'b0;
            r_halt_pend <= 1'b0;
            r_addr      <= 32'd0;
            r_store     <= 32'd0;
            r_iload     <= 32'd0;
            r_dload     <= 32'd0;
        end else begin
            // Grant-time latch: the access runs from these copies, not the live inputs.
            if (r_state == S_IDLE && !halt) begin
                if (w_data_req) begin
                    r_addr  <= daddr;
                    r_store <= dstore;
                    r_wr    <= dWEN;
                end else if (iREN) begin
                    r_addr <= iaddr;
                    r_wr   <= 1'b0;
                end
            end
            if (r_state == S_DREQ && ram_ready && !r_wr)
                r_dload <= ramload;
            if (r_state == S_IREQ && ram_ready)
                r_iload <= ramload;
            if (w_in_req && halt)
                r_halt_pend <= 1'b1;
        end
    end

    assign ihit     = (r_state == S_IDONE);
    assign dhit     = (r_state == S_DDONE);
    assign halted   = (r_state == S_HALT);
    assign ramREN   = (r_state == S_IREQ) || ((r_state == S_DREQ) && !r_wr);
    assign ramWEN   = (r_state == S_DREQ) && r_wr;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign iload    = r_iload;
    assign dload    = r_dload;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN, halt, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        ihit, dhit, ramREN, ramWEN, halted, err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [5:0]  flags;

    int tests = 0;
    int fails = 0;

    // {ihit, dhit, ramREN, ramWEN, halted, err}
    assign flags = {ihit, dhit, ramREN, ramWEN, halted, err};

    mem_arbiter #(.TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .halt(halt),
        .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready),
        .halted(halted), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ram_ready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        tick(); tick();
        RST = 1'b0;
        tests++;
        if (flags !== 6'b000000) begin
            fails++; $display("FAIL reset_flags: got %b want 000000", flags);
        end
        tests++;
        if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin
            fails++; $display("FAIL reset_data: got %h %h %h %h want zeros", iload, dload, ramaddr, ramstore);
        end
    endtask

    task automatic test_fetch();
        iREN = 1; iaddr = 32'h40; ram_ready = 1; ramload = 32'h3C010001;
        tick();
        tests++;
        if (flags !== 6'b001000 || ramaddr !== 32'h40) begin
            fails++; $display("FAIL fetch_grant: got %b addr %h want 001000 addr 00000040", flags, ramaddr);
        end
        tick();
        iREN = 0; ram_ready = 0;
        tests++;
        if (flags !== 6'b100000 || iload !== 32'h3C010001) begin
            fails++; $display("FAIL fetch_hit: got %b iload %h want 100000 iload 3c010001", flags, iload);
        end
        tick();
        tests++;
        if (flags !== 6'b000000) begin
            fails++; $display("FAIL fetch_after: got %b want 000000", flags);
        end
    endtask

    task automatic test_priority();
        iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h100; ram_ready = 0; ramload = 32'hDEADBEEF;
        tick();
        tests++;
        if (flags !== 6'b001000 || ramaddr !== 32'h100) begin
            fails++; $display("FAIL prio_dgrant: got %b addr %h want 001000 addr 00000100", flags, ramaddr);
        end
        tick(); tick();
        tests++;
        if (flags !== 6'b001000 || ramaddr !== 32'h100) begin
            fails++; $display("FAIL prio_dwait: got %b addr %h want 001000 addr 00000100", flags, ramaddr);
        end
        ram_ready = 1;
        tick();
        dREN = 0; ram_ready = 0; ramload = 32'h8C220004;
        tests++;
        if (flags !== 6'b010000 || dload !== 32'hDEADBEEF) begin
            fails++; $display("FAIL prio_dhit: got %b dload %h want 010000 dload deadbeef", flags, dload);
        end
        tick();
        tests++;
        if (flags !== 6'b000000) begin
            fails++; $display("FAIL prio_idle: got %b want 000000", flags);
        end
        tick();
        ram_ready = 1;
        tests++;
        if (flags !== 6'b001000 || ramaddr !== 32'h44) begin
            fails++; $display("FAIL prio_igrant: got %b addr %h want 001000 addr 00000044", flags, ramaddr);
        end
        tick();
        iREN = 0; ram_ready = 0;
        tests++;
        if (flags !== 6'b100000 || iload !== 32'h8C220004) begin
            fails++; $display("FAIL prio_ihit: got %b iload %h want 100000 iload 8c220004", flags, iload);
        end
        tick();
    endtask

    task automatic test_write();
        dWEN = 1; daddr = 32'h200; dstore = 32'h12345678; ramload = 32'hFFFFFFFF; ram_ready = 0;
        tick();
        dWEN = 0; dREN = 1; daddr = 32'h999; dstore = 32'hAAAA5555;
        tests++;
        if (flags !== 6'b000100 || ramaddr !== 32'h200 || ramstore !== 32'h12345678) begin
            fails++; $display("FAIL write_grant: got %b %h %h want 000100 00000200 12345678", flags, ramaddr, ramstore);
        end
        tick();
        tests++;
        if (flags !== 6'b000100 || ramaddr !== 32'h200 || ramstore !== 32'h12345678) begin
            fails++; $display("FAIL write_hold: got %b %h %h want 000100 00000200 12345678", flags, ramaddr, ramstore);
        end
        ram_ready = 1; dREN = 0;
        tick();
        ram_ready = 0;
        tests++;
        if (flags !== 6'b010000 || dload !== 32'hDEADBEEF) begin
            fails++; $display("FAIL write_hit: got %b dload %h want 010000 dload deadbeef", flags, dload);
        end
        tick();
        tests++;
        if (flags !== 6'b000000) begin
            fails++; $display("FAIL write_after: got %b want 000000", flags);
        end
    endtask

    task automatic test_halt();
        iREN = 1; iaddr = 32'h48; ramload = 32'h2000000C; ram_ready = 0;
        tick();
        halt = 1;
        tick();
        halt = 0;
        tick();
        ram_ready = 1;
        tick();
        iREN = 1; dREN = 1; ram_ready = 0;
        tests++;
        if (flags !== 6'b100000 || iload !== 32'h2000000C) begin
            fails++; $display("FAIL halt_ihit: got %b iload %h want 100000 iload 2000000c", flags, iload);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (flags !== 6'b000010) begin
                fails++; $display("FAIL halt_parked[%0d]: got %b want 000010", i, flags);
            end
        end
        iREN = 0; dREN = 0;
    endtask

    task automatic test_rst_mid();
        test_reset();
        dREN = 1; daddr = 32'h300; ramload = 32'h55AA55AA;
        tick();
        tests++;
        if (flags !== 6'b001000) begin
            fails++; $display("FAIL rst_grant: got %b want 001000", flags);
        end
        RST = 1; ram_ready = 1; dREN = 0;
        tick();
        RST = 0; ram_ready = 0;
        tests++;
        if (flags !== 6'b000000 || {iload, dload, ramaddr, ramstore} !== 128'd0) begin
            fails++; $display("FAIL rst_abort: got %b %h %h want 000000 and zero data", flags, dload, ramaddr);
        end
        iREN = 1; iaddr = 32'h60;
        tick();
        iREN = 0;
        tests++;
        if (flags !== 6'b001000 || ramaddr !== 32'h60) begin
            fails++; $display("FAIL rst_idle_grant: got %b addr %h want 001000 addr 00000060", flags, ramaddr);
        end
    endtask

    task automatic test_timeout();
        test_reset();
        iREN = 1; iaddr = 32'h50; ram_ready = 0;
        tick();
        iREN = 0;
        tick(); tick(); tick();
        tests++;
        if (flags !== 6'b001000) begin
            fails++; $display("FAIL timeout_wait: got %b want 001000", flags);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        tests++;
        if (flags !== 6'b000011) begin
            fails++; $display("FAIL timeout_err: got %b want 000011", flags);
        end
`else
        for (int i = 0; i < 20; i++) begin
            tests++;
            if (flags !== 6'b001000) begin
                fails++; $display("FAIL timeout_persist[%0d]: got %b want 001000", i, flags);
            end
            tick();
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_halt();
        test_rst_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
